memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues aligned data-memory requests for loads/stores,
// stalls upstream until acknowledged, and formats load data for writeback.
module memory_access #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] read_data2_i,
    input  logic [4:0]      write_addr_reg_i,
    input  logic [2:0]      funct3_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            reg_write_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_be_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_rd_o,
    output logic            wb_reg_write_o,
    output logic            stall_o,
    output logic            fault_o
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      off_reg;
    logic [4:0]      rd_reg;

    logic            is_mem;
    logic            funct3_ok;
    logic            aligned;
    logic            legal;
    logic            accept;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_data;

    assign is_mem = mem_read_i | mem_write_i;

    always_comb begin
        funct3_ok = 1'b0;
        if (mem_read_i) begin
            funct3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                        (funct3_i == 3'b100) || (funct3_i == 3'b101);
        end else begin
            funct3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        end
    end

    always_comb begin
        aligned    = 1'b1;
        be_next    = 4'b0001 << alu_result_i[1:0];
        wdata_next = {4{read_data2_i[7:0]}};
        case (funct3_i[1:0])
            2'b01: begin
                aligned    = ~alu_result_i[0];
                be_next    = 4'b0011 << alu_result_i[1:0];
                wdata_next = {2{read_data2_i[15:0]}};
            end
            2'b10: begin
                aligned    = (alu_result_i[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = read_data2_i;
            end
            default: ;
        endcase
    end

    assign legal   = (mem_read_i ^ mem_write_i) & funct3_ok & aligned;
    assign accept  = (state_reg == IDLE) & valid_i & is_mem & legal;
    assign stall_o = accept | ((state_reg == ACCESS) & ~dmem_ack_i);

    // Halfword offsets are always 0 or 2, so one byte-granular shift serves both sizes.
    assign rdata_shifted = dmem_rdata_i >> {off_reg, 3'b000};

    always_comb begin
        case (funct3_reg)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            funct3_reg     <= 3'd0;
            off_reg        <= 2'd0;
            rd_reg         <= 5'd0;
            dmem_req_o     <= 1'b0;
            dmem_we_o      <= 1'b0;
            dmem_addr_o    <= '0;
            dmem_wdata_o   <= '0;
            dmem_be_o      <= 4'd0;
            wb_valid_o     <= 1'b0;
            wb_data_o      <= '0;
            wb_rd_o        <= 5'd0;
            wb_reg_write_o <= 1'b0;
            fault_o        <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            fault_o    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid_i && !is_mem) begin
                        wb_valid_o     <= 1'b1;
                        wb_data_o      <= alu_result_i;
                        wb_rd_o        <= write_addr_reg_i;
                        wb_reg_write_o <= reg_write_i && (write_addr_reg_i != 5'd0);
                    end else if (accept) begin
                        state_reg    <= ACCESS;
                        funct3_reg   <= funct3_i;
                        off_reg      <= alu_result_i[1:0];
                        rd_reg       <= write_addr_reg_i;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_write_i;
                        dmem_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
                        dmem_wdata_o <= wdata_next;
                        dmem_be_o    <= be_next;
                    end else if (valid_i) begin
                        // Illegal access retires as a non-writing instruction with a fault flag.
                        fault_o        <= 1'b1;
                        wb_valid_o     <= 1'b1;
                        wb_data_o      <= alu_result_i;
                        wb_rd_o        <= write_addr_reg_i;
                        wb_reg_write_o <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack_i) begin
                        state_reg      <= IDLE;
                        dmem_req_o     <= 1'b0;
                        wb_valid_o     <= 1'b1;
                        wb_rd_o        <= rd_reg;
                        wb_reg_write_o <= ~dmem_we_o && (rd_reg != 5'd0);
                        if (!dmem_we_o) begin
                            wb_data_o <= load_data;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
